// File: rtl/baud_tick_if.sv
// Baud tick generator bus.
//   master : drives enable, baud_select, resync; samples the ticks and os_phase
//   slave  : the generator itself
//   enable       run / hold-at-zero
//   baud_select  rate index 0..7 (300 .. 115200 baud)
//   resync       one-cycle re-phase pulse from the receiver
//   sample_tick  oversample strobe
//   bit_tick     last sample of each bit
//   mid_tick     bit-centre strobe
//   os_phase     current oversample index
interface baud_tick_if #(
  parameter int OVERSAMPLE = 16
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  logic            enable;
  logic [2:0]      baud_select;
  logic            resync;
  logic            sample_tick;
  logic            bit_tick;
  logic            mid_tick;
  logic [PH_W-1:0] os_phase;

  modport master (
    output enable, baud_select, resync,
    input  sample_tick, bit_tick, mid_tick, os_phase
  );

  modport slave (
    input  enable, baud_select, resync,
    output sample_tick, bit_tick, mid_tick, os_phase
  );
endinterface

// File: rtl/baud_tick_generator.sv
// Baud-rate tick generator for the UART TX/RX pair.
// Produces an oversampled sample_tick, a per-bit bit_tick and a bit-centre
// mid_tick from the system clock; the rate comes from an 8-entry table.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    baud_tick_if.slave (enable, baud_select, resync -> ticks, os_phase)
// Optional macro BAUD_FRAC_EN: replaces the integer divider with an ACC_W-bit
// phase accumulator whose carry out is the sample strobe.
module baud_tick_generator #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int CNT_W       = 16,
  parameter int ACC_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  baud_tick_if.slave bus
);
  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

  function automatic longint rate_of(input int i);
    case (i)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be even and within 4..32");
  end

  logic [2:0]      sel_q;
  logic            clr;    // counters to zero, no tick this cycle
  logic            term;   // the divider/accumulator wraps this cycle
  logic [PH_W-1:0] os_phase;
  logic            sample_q, bit_q, mid_q;

  // enable low, resync and a rate change all collapse to the same action.
  assign clr = !bus.enable || bus.resync || (bus.baud_select != sel_q);

`ifdef BAUD_FRAC_EN
  function automatic longint inc_of(input int i);
    longint num = rate_of(i) * OVERSAMPLE * (longint'(1) << ACC_W);
    return (num + longint'(CLK_FREQ_HZ / 2)) / longint'(CLK_FREQ_HZ);
  endfunction

  localparam logic [ACC_W-1:0] INC_TAB [8] = '{
    ACC_W'(inc_of(0)), ACC_W'(inc_of(1)), ACC_W'(inc_of(2)), ACC_W'(inc_of(3)),
    ACC_W'(inc_of(4)), ACC_W'(inc_of(5)), ACC_W'(inc_of(6)), ACC_W'(inc_of(7))
  };

  for (genvar g = 0; g < 8; g++) begin : g_chk
    if (inc_of(g) < 1 || inc_of(g) >= (longint'(1) << ACC_W)) begin : g_bad_inc
      $error("phase increment out of range for ACC_W");
    end
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, INC_TAB[sel_q]};
  assign term    = acc_sum[ACC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= acc_sum[ACC_W-1:0];
  end
`else
  function automatic longint div_of(input int i);
    longint r = rate_of(i) * OVERSAMPLE;
    return (longint'(CLK_FREQ_HZ) + r / 2) / r;
  endfunction

  // Terminal count per rate: divisor - 1.
  localparam logic [CNT_W-1:0] DIV_LAST [8] = '{
    CNT_W'(div_of(0) - 1), CNT_W'(div_of(1) - 1), CNT_W'(div_of(2) - 1), CNT_W'(div_of(3) - 1),
    CNT_W'(div_of(4) - 1), CNT_W'(div_of(5) - 1), CNT_W'(div_of(6) - 1), CNT_W'(div_of(7) - 1)
  };

  for (genvar g = 0; g < 8; g++) begin : g_chk
    if (div_of(g) < 2 || div_of(g) >= (longint'(1) << CNT_W)) begin : g_bad_div
      $error("divisor below 2 or too wide for CNT_W");
    end
  end
  if (ACC_W < 1) begin : g_bad_acc_w
    $error("ACC_W must be positive");
  end

  logic [CNT_W-1:0] div_cnt;

  assign term = (div_cnt == DIV_LAST[sel_q]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (clr)  div_cnt <= '0;
    else if (term) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end
`endif

  // Tick and phase stage, shared by both divider flavours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      os_phase <= '0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      sel_q    <= bus.baud_select;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
      if (clr) begin
        os_phase <= '0;
      end else if (term) begin
        sample_q <= 1'b1;
        bit_q    <= (os_phase == PH_LAST);
        mid_q    <= (os_phase == PH_MID);
        os_phase <= (os_phase == PH_LAST) ? '0 : os_phase + 1'b1;
      end
    end
  end

  assign bus.sample_tick = sample_q;
  assign bus.bit_tick    = bit_q;
  assign bus.mid_tick    = mid_q;
  assign bus.os_phase    = os_phase;
endmodule
